tsmc65lp_rf_model: RTL and testbench

//  Cycle-accurate behavioural model of the tsmc65lp register-file macros.
//  - 1rf_lg6_w32_all: single port, whole-word write.
//  - 1rf_lg6_w32_byte: single port, per-bit write enable driven per byte lane.
//  - 2rf_lg10_w32_bit: 1 read + 1 write port, per-bit write enable.

---
 rtl/tsmc65lp_rf_pkg.sv | 17 +
 rtl/tsmc65lp_rf_bitarray.sv | 30 +++
 rtl/tsmc65lp_rf_model.sv | 87 ++++++++
 tb/tb_tsmc65lp_rf_model.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/tsmc65lp_rf_pkg.sv
// Shared constants and helpers for the tsmc65lp register-file behavioural models.
package tsmc65lp_rf_pkg;

    localparam logic [2:0] EMA_DEFAULT  = 3'd3;
    localparam logic [1:0] EMAW_DEFAULT = 2'd1;
    localparam logic [2:0] EMAB_DEFAULT = 3'd3;

    // mask[i]=1 enables byte lane i; the result is the macro's active-low per-bit WEN.
    function automatic logic [31:0] expand_byte_mask(input logic [3:0] mask);
        logic [31:0] wen;
        for (int i = 0; i < 4; i++) begin
            wen[8*i +: 8] = {8{~mask[i]}};
        end
        return wen;
    endfunction

endpackage

// File: rtl/tsmc65lp_rf_bitarray.sv
// Storage array with a per-bit masked synchronous write port and an asynchronous read tap.
module tsmc65lp_rf_bitarray
    import tsmc65lp_rf_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wmask_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    // Deliberately unreset: contents survive reset, unwritten words stay X.
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= (mem_q[waddr_i] & ~wmask_i) | (wdata_i & wmask_i);
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/tsmc65lp_rf_model.sv
// Cycle-accurate model of the tsmc65lp 1rf/2rf macros: control decode, Q register,
// synchronous reset and retention around the bit array.
module tsmc65lp_rf_model
    import tsmc65lp_rf_pkg::*;
#(
    parameter int ADDR_W   = 6,
    parameter int DATA_W   = 32,
    parameter bit USE_WEN  = 1'b1,
    parameter bit TWO_PORT = 1'b0
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              CEN,
    input  logic              GWEN,
    input  logic [DATA_W-1:0] WEN,
    input  logic [ADDR_W-1:0] A,
    input  logic [DATA_W-1:0] D,
    output logic [DATA_W-1:0] Q,
    input  logic              CENB,
    input  logic [DATA_W-1:0] WENB,
    input  logic [ADDR_W-1:0] AB,
    input  logic [DATA_W-1:0] DB,
    input  logic [2:0]        EMA,
    input  logic [1:0]        EMAW,
    input  logic [2:0]        EMAB,
    input  logic              RET1N
);

    logic              active;
    logic              rd_en;
    logic              wr_en;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic [DATA_W-1:0] w_mask;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] q_d;
    logic [DATA_W-1:0] q_q;

    // Margin-adjust pins exist only for netlist compatibility.
    logic unused_margin;
    assign unused_margin = ^{EMA, EMAW, EMAB};

    assign active = RSTN && RET1N;
    assign rd_en  = active && !CEN && (TWO_PORT || GWEN);

    always_comb begin
        wr_en  = 1'b0;
        w_addr = A;
        w_data = D;
        w_mask = USE_WEN ? ~WEN : '1;
        if (TWO_PORT) begin
            wr_en  = active && !CENB;
            w_addr = AB;
            w_data = DB;
            w_mask = USE_WEN ? ~WENB : '1;
        end else begin
            wr_en  = active && !CEN && !GWEN;
        end
    end

    tsmc65lp_rf_bitarray #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk_i   (CLK),
        .we_i    (wr_en),
        .waddr_i (w_addr),
        .wmask_i (w_mask),
        .wdata_i (w_data),
        .raddr_i (A),
        .rdata_o (rd_data)
    );

    // rd_data is sampled before the array's write lands, giving read-before-write.
    assign q_d = rd_en ? rd_data : q_q;

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q = q_q;

endmodule

// File: tb/tb_tsmc65lp_rf_model.sv
// Directed self-checking bench for the byte-mask 1rf, full-word 1rf and 2rf configurations.
module tb_tsmc65lp_rf_model;
    import tsmc65lp_rf_pkg::*;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic RSTN, RET1N;
    logic [2:0] ema;
    logic [1:0] emaw;
    logic [2:0] emab;

    // byte-mask 1rf
    logic        b_cen, b_gwen;
    logic [31:0] b_wen, b_d, b_q;
    logic [5:0]  b_a;
    // full-word 1rf
    logic        f_cen, f_gwen;
    logic [31:0] f_wen, f_d, f_q;
    logic [5:0]  f_a;
    // 2rf
    logic        t_cen, t_gwen, t_cenb;
    logic [31:0] t_wen, t_d, t_q, t_wenb, t_db;
    logic [9:0]  t_a, t_ab;

    int n_checks = 0;
    int n_fail   = 0;

    tsmc65lp_rf_model #(.ADDR_W(6), .DATA_W(32), .USE_WEN(1'b1), .TWO_PORT(1'b0)) u_byte (
        .CLK(CLK), .RSTN(RSTN), .CEN(b_cen), .GWEN(b_gwen), .WEN(b_wen), .A(b_a), .D(b_d),
        .Q(b_q), .CENB(1'b1), .WENB('1), .AB(6'd0), .DB(32'd0),
        .EMA(ema), .EMAW(emaw), .EMAB(emab), .RET1N(RET1N));

    tsmc65lp_rf_model #(.ADDR_W(6), .DATA_W(32), .USE_WEN(1'b0), .TWO_PORT(1'b0)) u_all (
        .CLK(CLK), .RSTN(RSTN), .CEN(f_cen), .GWEN(f_gwen), .WEN(f_wen), .A(f_a), .D(f_d),
        .Q(f_q), .CENB(1'b1), .WENB('1), .AB(6'd0), .DB(32'd0),
        .EMA(ema), .EMAW(emaw), .EMAB(emab), .RET1N(RET1N));

    tsmc65lp_rf_model #(.ADDR_W(10), .DATA_W(32), .USE_WEN(1'b1), .TWO_PORT(1'b1)) u_2rf (
        .CLK(CLK), .RSTN(RSTN), .CEN(t_cen), .GWEN(t_gwen), .WEN(t_wen), .A(t_a), .D(t_d),
        .Q(t_q), .CENB(t_cenb), .WENB(t_wenb), .AB(t_ab), .DB(t_db),
        .EMA(ema), .EMAW(emaw), .EMAB(emab), .RET1N(RET1N));

    // Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_all();
        @(negedge CLK);
        b_cen = 1'b1; b_gwen = 1'b1;
        f_cen = 1'b1; f_gwen = 1'b1;
        t_cen = 1'b1; t_gwen = 1'b1; t_cenb = 1'b1;
    endtask

    task automatic byte_op(input logic cen, input logic gwen, input logic [31:0] wen,
                           input logic [5:0] a, input logic [31:0] d);
        @(negedge CLK);
        b_cen = cen; b_gwen = gwen; b_wen = wen; b_a = a; b_d = d;
        tick();
        @(negedge CLK);
        b_cen = 1'b1; b_gwen = 1'b1;
    endtask

    task automatic full_op(input logic gwen, input logic [31:0] wen,
                           input logic [5:0] a, input logic [31:0] d);
        @(negedge CLK);
        f_cen = 1'b0; f_gwen = gwen; f_wen = wen; f_a = a; f_d = d;
        tick();
        @(negedge CLK);
        f_cen = 1'b1; f_gwen = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        RSTN = 1'b0;
        tick();
        @(negedge CLK);
        RSTN = 1'b1;
        n_checks++;
        if (b_q !== 32'h0) begin n_fail++; $display("FAIL reset_byte_q: got %h want %h", b_q, 32'h0); end
        n_checks++;
        if (f_q !== 32'h0) begin n_fail++; $display("FAIL reset_all_q: got %h want %h", f_q, 32'h0); end
        n_checks++;
        if (t_q !== 32'h0) begin n_fail++; $display("FAIL reset_2rf_q: got %h want %h", t_q, 32'h0); end
    endtask

    task automatic test_byte_write();
        byte_op(1'b0, 1'b0, 32'h0, 6'd5, 32'hDEADBEEF);
        n_checks++;
        if (b_q !== 32'h0) begin n_fail++; $display("FAIL write_no_through: got %h want %h", b_q, 32'h0); end
        byte_op(1'b0, 1'b1, 32'h0, 6'd5, 32'h0);
        n_checks++;
        if (b_q !== 32'hDEADBEEF) begin n_fail++; $display("FAIL byte_read: got %h want %h", b_q, 32'hDEADBEEF); end
    endtask

    task automatic test_byte_mask();
        byte_op(1'b0, 1'b0, 32'h0, 6'd7, 32'h0);
        byte_op(1'b0, 1'b0, expand_byte_mask(4'b1001), 6'd7, 32'hFFFFFFFF);
        byte_op(1'b0, 1'b1, 32'h0, 6'd7, 32'h0);
        n_checks++;
        if (b_q !== 32'hFF0000FF) begin n_fail++; $display("FAIL mask_1001: got %h want %h", b_q, 32'hFF0000FF); end
        byte_op(1'b0, 1'b0, expand_byte_mask(4'b0010), 6'd5, 32'h11223344);
        n_checks++;
        if (b_q !== 32'hFF0000FF) begin n_fail++; $display("FAIL mask_write_holds_q: got %h want %h", b_q, 32'hFF0000FF); end
        byte_op(1'b0, 1'b1, 32'h0, 6'd5, 32'h0);
        n_checks++;
        if (b_q !== 32'hDEAD33EF) begin n_fail++; $display("FAIL mask_0010: got %h want %h", b_q, 32'hDEAD33EF); end
    endtask

    task automatic test_use_wen0();
        full_op(1'b0, 32'hFFFFFFFF, 6'd63, 32'hA5A5A5A5);
        full_op(1'b1, 32'h0, 6'd63, 32'h0);
        n_checks++;
        if (f_q !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL all_full_word: got %h want %h", f_q, 32'hA5A5A5A5); end
        full_op(1'b0, 32'hFFFF0000, 6'd63, 32'h0F0F0F0F);
        full_op(1'b1, 32'h0, 6'd63, 32'h0);
        n_checks++;
        if (f_q !== 32'h0F0F0F0F) begin n_fail++; $display("FAIL all_ignores_wen: got %h want %h", f_q, 32'h0F0F0F0F); end
    endtask

    task automatic test_idle_retention();
        byte_op(1'b1, 1'b0, 32'h0, 6'd5, 32'h0);
        n_checks++;
        if (b_q !== 32'hDEAD33EF) begin n_fail++; $display("FAIL cen_idle_q: got %h want %h", b_q, 32'hDEAD33EF); end
        @(negedge CLK);
        RET1N = 1'b0;
        b_cen = 1'b0; b_gwen = 1'b0; b_wen = 32'h0; b_a = 6'd5; b_d = 32'h0;
        tick();
        @(negedge CLK);
        b_gwen = 1'b1; b_a = 6'd7;
        tick();
        n_checks++;
        if (b_q !== 32'hDEAD33EF) begin n_fail++; $display("FAIL ret_read_q: got %h want %h", b_q, 32'hDEAD33EF); end
        @(negedge CLK);
        RET1N = 1'b1;
        b_cen = 1'b1;
        byte_op(1'b0, 1'b1, 32'h0, 6'd7, 32'h0);
        n_checks++;
        if (b_q !== 32'hFF0000FF) begin n_fail++; $display("FAIL post_ret_read7: got %h want %h", b_q, 32'hFF0000FF); end
        byte_op(1'b0, 1'b1, 32'h0, 6'd5, 32'h0);
        n_checks++;
        if (b_q !== 32'hDEAD33EF) begin n_fail++; $display("FAIL no_write_idle: got %h want %h", b_q, 32'hDEAD33EF); end
    endtask

    task automatic test_reset_mid();
        @(negedge CLK);
        RSTN = 1'b0;
        b_cen = 1'b0; b_gwen = 1'b0; b_wen = 32'h0; b_a = 6'd5; b_d = 32'h0;
        tick();
        n_checks++;
        if (b_q !== 32'h0) begin n_fail++; $display("FAIL mid_reset_q: got %h want %h", b_q, 32'h0); end
        @(negedge CLK);
        RSTN = 1'b1;
        b_cen = 1'b1; b_gwen = 1'b1;
        byte_op(1'b0, 1'b1, 32'h0, 6'd5, 32'h0);
        n_checks++;
        if (b_q !== 32'hDEAD33EF) begin n_fail++; $display("FAIL contents_kept: got %h want %h", b_q, 32'hDEAD33EF); end
    endtask

    task automatic test_2rf();
        @(negedge CLK);
        t_cenb = 1'b0; t_ab = 10'd1023; t_db = 32'hCAFEF00D; t_wenb = 32'h0;
        tick();
        @(negedge CLK);
        t_cenb = 1'b1;
        t_cen = 1'b0; t_gwen = 1'b0; t_a = 10'd1023; t_d = 32'h0; t_wen = 32'h0;
        tick();
        n_checks++;
        if (t_q !== 32'hCAFEF00D) begin n_fail++; $display("FAIL 2rf_first_read: got %h want %h", t_q, 32'hCAFEF00D); end
        @(negedge CLK);
        t_cenb = 1'b0; t_ab = 10'd1023; t_db = 32'h12345678; t_wenb = 32'h0;
        t_cen = 1'b0; t_a = 10'd1023;
        tick();
        n_checks++;
        if (t_q !== 32'hCAFEF00D) begin n_fail++; $display("FAIL 2rf_rbw_old: got %h want %h", t_q, 32'hCAFEF00D); end
        @(negedge CLK);
        t_cenb = 1'b1;
        tick();
        n_checks++;
        if (t_q !== 32'h12345678) begin n_fail++; $display("FAIL 2rf_rbw_new: got %h want %h", t_q, 32'h12345678); end
        @(negedge CLK);
        t_cen = 1'b1;
        t_cenb = 1'b0; t_ab = 10'd1023; t_db = 32'hFFFFFFFF; t_wenb = expand_byte_mask(4'b0100);
        tick();
        @(negedge CLK);
        t_cenb = 1'b1; t_cen = 1'b0; t_a = 10'd1023;
        tick();
        n_checks++;
        if (t_q !== 32'h12FF5678) begin n_fail++; $display("FAIL 2rf_wenb_mask: got %h want %h", t_q, 32'h12FF5678); end
        @(negedge CLK);
        t_cen = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within %0d ns", 200000);
        $fatal(1, "timeout");
    end

    initial begin
        RSTN = 1'b1; RET1N = 1'b1;
        ema = EMA_DEFAULT; emaw = EMAW_DEFAULT; emab = EMAB_DEFAULT;
        b_cen = 1'b1; b_gwen = 1'b1; b_wen = '1; b_a = '0; b_d = '0;
        f_cen = 1'b1; f_gwen = 1'b1; f_wen = '1; f_a = '0; f_d = '0;
        t_cen = 1'b1; t_gwen = 1'b1; t_wen = '1; t_a = '0; t_d = '0;
        t_cenb = 1'b1; t_wenb = '1; t_ab = '0; t_db = '0;
        idle_all();
        test_reset();
        test_byte_write();
        test_byte_mask();
        test_use_wen0();
        test_idle_retention();
        test_reset_mid();
        test_2rf();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
